// File: rtl/axi_slv_rd_ctrl_pkg.sv
// Shared widths, AXI codes and FSM states for the SRAM read responder.
// Imported by the interface, the address generator and the top.
package axi_slv_rd_ctrl_pkg;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_LEN_W  = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_4_BYTE = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_e;
endpackage

// File: rtl/axi_slv_rd_ctrl_if.sv
// AXI4 AR + R channel bundle between the interconnect
// and the SRAM read responder.
interface axi_slv_rd_ctrl_if
  import axi_slv_rd_ctrl_pkg::*;
#(
  parameter int ID_W   = AXI_ID_W,
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int LEN_W  = AXI_LEN_W
);
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, arid, araddr, arlen,
    output arsize, arburst, rready,
    input  arready, rvalid, rid, rdata,
    input  rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen,
    input  arsize, arburst, rready,
    output arready, rvalid, rid, rdata,
    output rresp, rlast
  );
endinterface

// File: rtl/axi_slv_rd_ctrl_addr_gen.sv
// Combinational beat address step, SRAM window decode
// and per-beat response classification.
module axi_slv_addr_gen
  import axi_slv_rd_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = AXI_ADDR_W,
  parameter int                MEM_AW    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_burst,
  input  logic [2:0]        i_size,
  output logic [ADDR_W-1:0] o_next_addr,
  output logic [MEM_AW-1:0] o_word_addr,
  output logic [1:0]        o_resp
);
  logic [ADDR_W-1:0] w_off;
  logic              w_in_rng;
  logic              w_bad_req;

  // Modulo offset: anything below BASE wraps high and decodes out.
  assign w_off     = i_addr - BASE_ADDR;
  assign w_in_rng  = (w_off >> (MEM_AW + 2)) == '0;
  assign w_bad_req = (i_size != SIZE_4_BYTE) || i_burst[1];

  assign o_word_addr = w_off[MEM_AW+1:2];
  assign o_next_addr = (i_burst == BURST_FIXED) ?
                       i_addr : i_addr + ADDR_W'(4);

  always_comb begin
    o_resp = RESP_OKAY;
    priority case (1'b1)
      w_bad_req: o_resp = RESP_SLVERR;
      !w_in_rng: o_resp = RESP_DECERR;
      default:   o_resp = RESP_OKAY;
    endcase
  end
endmodule

// File: rtl/axi_slv_rd_ctrl.sv
// AXI4 read responder for a 1-cycle-latency SRAM,
// one outstanding burst, one SRAM read per R beat.
module axi_slv_rd_ctrl
  import axi_slv_rd_ctrl_pkg::*;
#(
  parameter int                ID_W      = AXI_ID_W,
  parameter int                ADDR_W    = AXI_ADDR_W,
  parameter int                DATA_W    = AXI_DATA_W,
  parameter int                LEN_W     = AXI_LEN_W,
  parameter int                MEM_AW    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  axi_slv_rd_ctrl_if.slave   s,
  output logic               mem_ren,
  output logic [MEM_AW-1:0]  mem_raddr,
  input  logic [DATA_W-1:0]  mem_rdata
);
  state_e            r_state;
  state_e            w_nxt;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [DATA_W-1:0] r_rdata;
  logic              r_hold;

  logic [ADDR_W-1:0] w_next_addr;
  logic [MEM_AW-1:0] w_word;
  logic [1:0]        w_resp;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_ok;
  logic [DATA_W-1:0] w_beat;

  axi_slv_addr_gen #(
    .ADDR_W    (ADDR_W),
    .MEM_AW    (MEM_AW),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .i_addr      (r_addr),
    .i_burst     (r_burst),
    .i_size      (r_size),
    .o_next_addr (w_next_addr),
    .o_word_addr (w_word),
    .o_resp      (w_resp)
  );

  assign w_ar_hs = (r_state == ST_IDLE) && s.arvalid;
  assign w_r_hs  = (r_state == ST_DATA) && s.rready;
  assign w_ok    = (w_resp == RESP_OKAY);
  assign w_beat  = w_ok ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (s.arvalid) w_nxt = ST_REQ;
      ST_REQ:  w_nxt = ST_DATA;
      ST_DATA: begin
        if (s.rready)
          w_nxt = (r_cnt == r_len) ? ST_IDLE : ST_REQ;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_rdata <= '0;
      r_hold  <= 1'b0;
    end else if (w_ar_hs) begin
      r_id    <= s.arid;
      r_addr  <= {s.araddr[ADDR_W-1:2], 2'b00};
      r_len   <= s.arlen;
      r_cnt   <= '0;
      r_size  <= s.arsize;
      r_burst <= s.arburst;
    end else if (w_r_hs) begin
      r_hold  <= 1'b0;
      r_cnt   <= r_cnt + LEN_W'(1);
      r_addr  <= w_next_addr;
    end else if (r_state == ST_DATA) begin
      // SRAM data is only valid in the first DATA cycle.
      r_hold  <= 1'b1;
      if (!r_hold) r_rdata <= w_beat;
    end
  end

  assign s.arready = (r_state == ST_IDLE);
  assign s.rvalid  = (r_state == ST_DATA);
  assign s.rid     = r_id;
  assign s.rdata   = (r_state != ST_DATA) ? '0 :
                     r_hold ? r_rdata : w_beat;
  assign s.rresp   = (r_state == ST_DATA) ? w_resp : RESP_OKAY;
  assign s.rlast   = (r_state == ST_DATA) && (r_cnt == r_len);
  assign mem_ren   = (r_state == ST_REQ) && w_ok;
  assign mem_raddr = mem_ren ? w_word : '0;
endmodule

// File: tb/tb_axi_slv_rd_ctrl.sv
// Randomized bench for axi_slv_rd_ctrl against a
// beat-list reference model and an SRAM model.
module tb_axi_slv_rd_ctrl;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          MAW   = 12;
  localparam int          DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_slv_rd_ctrl_if #(
    .ID_W(4), .ADDR_W(32), .DATA_W(32), .LEN_W(8)
  ) axi ();

  logic            mem_ren;
  logic [MAW-1:0]  mem_raddr;
  logic [31:0]     mem_rdata = '0;
  logic [31:0]     mem [DEPTH];

  axi_slv_rd_ctrl #(
    .ID_W(4), .ADDR_W(32), .DATA_W(32), .LEN_W(8),
    .MEM_AW(MAW), .BASE_ADDR(BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (axi),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [MAW-1:0] ren_q[$];
  logic [MAW-1:0] exp_ren[$];
  logic [31:0]    exp_d[$];
  logic [1:0]     exp_r[$];

  always @(posedge clk) begin
    if (mem_ren) begin
      ren_q.push_back(mem_raddr);
      mem_rdata <= mem[mem_raddr];
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Expected beats straight from the address/response rules.
  task automatic model(input logic [31:0] addr,
                       input int len,
                       input logic [2:0] size,
                       input logic [1:0] bt);
    logic [31:0] a;
    logic [31:0] off;
    logic [1:0]  rsp;
    exp_d.delete();
    exp_r.delete();
    exp_ren.delete();
    a = addr & 32'hFFFF_FFFC;
    for (int i = 0; i <= len; i++) begin
      off = a - BASE;
      if (size != 3'd2 || bt >= 2'd2) rsp = 2'b10;
      else if (off >= 32'(4 * DEPTH)) rsp = 2'b11;
      else rsp = 2'b00;
      exp_r.push_back(rsp);
      exp_d.push_back(rsp == 2'b00 ? mem[off[13:2]] : 32'h0);
      if (rsp == 2'b00) exp_ren.push_back(off[13:2]);
      if (bt == 2'b01) a = a + 32'd4;
    end
  endtask

  task automatic send_ar(input logic [3:0] id,
                         input logic [31:0] addr,
                         input logic [7:0] len,
                         input logic [2:0] size,
                         input logic [1:0] bt);
    @(negedge clk);
    axi.arid    = id;
    axi.araddr  = addr;
    axi.arlen   = len;
    axi.arsize  = size;
    axi.arburst = bt;
    axi.arvalid = 1'b1;
    chk("arready_idle", 64'(axi.arready), 64'd1);
    @(posedge clk);
    #1 axi.arvalid = 1'b0;
  endtask

  // Waits for one beat, checks it (stable under stall), accepts it.
  task automatic take_beat(input int b, input int len,
                           input logic [3:0] id, input int st);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!axi.rvalid && k < 20);
    chk("r_latency", 64'(k), 64'd2);
    for (int s2 = 0; s2 <= st; s2++) begin
      if (s2 > 0) @(negedge clk);
      chk("rvalid", 64'(axi.rvalid), 64'd1);
      chk("rdata", 64'(axi.rdata), 64'(exp_d[b]));
      chk("rid", 64'(axi.rid), 64'(id));
      chk("rresp", 64'(axi.rresp), 64'(exp_r[b]));
      chk("rlast", 64'(axi.rlast), 64'(b == len));
      chk("arready_busy", 64'(axi.arready), 64'd0);
    end
    axi.rready = 1'b1;
    @(posedge clk);
    #1 axi.rready = 1'b0;
  endtask

  task automatic burst(input logic [3:0] id,
                       input logic [31:0] addr,
                       input int len,
                       input logic [2:0] size,
                       input logic [1:0] bt,
                       input int max_st,
                       input int st0);
    int st;
    model(addr, len, size, bt);
    ren_q.delete();
    send_ar(id, addr, 8'(len), size, bt);
    for (int b = 0; b <= len; b++) begin
      st = (b == 0 && st0 > 0) ? st0 : int'($urandom_range(max_st, 0));
      take_beat(b, len, id, st);
    end
    @(negedge clk);
    chk("arready_after", 64'(axi.arready), 64'd1);
    chk("rvalid_after", 64'(axi.rvalid), 64'd0);
    chk("ren_count", 64'(ren_q.size()), 64'(exp_ren.size()));
    for (int i = 0; i < exp_ren.size() && i < ren_q.size(); i++)
      chk("ren_addr", 64'(ren_q[i]), 64'(exp_ren[i]));
  endtask

  task automatic chk_reset_vals();
    chk("rst_arready", 64'(axi.arready), 64'd1);
    chk("rst_rvalid", 64'(axi.rvalid), 64'd0);
    chk("rst_rlast", 64'(axi.rlast), 64'd0);
    chk("rst_rid", 64'(axi.rid), 64'd0);
    chk("rst_rdata", 64'(axi.rdata), 64'd0);
    chk("rst_rresp", 64'(axi.rresp), 64'd0);
    chk("rst_mem_ren", 64'(mem_ren), 64'd0);
    chk("rst_mem_raddr", 64'(mem_raddr), 64'd0);
  endtask

  initial begin
    int off;
    logic [1:0] bt;
    logic [2:0] sz;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[4] = 32'hDEAD_BEEF;
    axi.arvalid = 1'b0;
    axi.arid    = '0;
    axi.araddr  = '0;
    axi.arlen   = '0;
    axi.arsize  = 3'd2;
    axi.arburst = 2'b01;
    axi.rready  = 1'b0;
    #1 chk_reset_vals();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    burst(4'd3, BASE + 32'h10, 0, 3'd2, 2'b01, 0, 0);
    chk("single_data", 64'(exp_d[0]), 64'h0000_0000_DEAD_BEEF);
    burst(4'd5, BASE + 32'h8, 3, 3'd2, 2'b01, 0, 0);
    burst(4'd5, BASE + 32'h8, 3, 3'd2, 2'b01, 0, 5);
    burst(4'd6, BASE + 32'h20, 2, 3'd2, 2'b00, 0, 0);
    burst(4'd1, BASE - 32'd4, 1, 3'd2, 2'b01, 0, 0);
    burst(4'd2, BASE + 32'h40, 0, 3'd1, 2'b01, 0, 0);
    burst(4'd9, BASE + 32'h40, 1, 3'd2, 2'b10, 0, 0);
    burst(4'd7, BASE + 32'(4 * (DEPTH - 1)), 1, 3'd2, 2'b01, 0, 0);
    burst(4'd8, BASE + 32'h33, 2, 3'd2, 2'b01, 1, 0);
    burst(4'hA, BASE + 32'(4 * (DEPTH - 200)), 255, 3'd2, 2'b01, 0, 0);

    for (int n = 0; n < 30; n++) begin
      off = int'($urandom_range(4 * DEPTH + 128, 0)) - 64;
      bt  = ($urandom_range(9, 0) == 0) ? 2'(3 - $urandom_range(1, 0)) :
            2'($urandom_range(1, 0));
      sz  = ($urandom_range(9, 0) == 0) ? 3'($urandom_range(7, 0)) : 3'd2;
      burst(4'($urandom), BASE + 32'(off), int'($urandom_range(7, 0)),
            sz, bt, 3, 0);
    end

    // Reset while beat 1 of 4 is presented.
    model(BASE + 32'h100, 3, 3'd2, 2'b01);
    send_ar(4'hC, BASE + 32'h100, 8'd3, 3'd2, 2'b01);
    take_beat(0, 3, 4'hC, 0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_rvalid", 64'(axi.rvalid), 64'd1);
    rst_n = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    burst(4'hB, BASE + 32'h10, 1, 3'd2, 2'b01, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
